kid_death_ctrl: RTL and testbench

- Game-state controller that consumes the trap hit flags (apple traps, spikes) and decides kid death, game-over display and respawn.
- Drives the trap-reset pulse back into the trap blocks and freezes kid movement.
- Generates the "GAME OVER" banner pixel flag and sprite-memory address in the same address space as the apple sprites.
- Sits between the trap modules, the kid movement logic and the colour mapper; updates once per frame_clk.

---
 rtl/kid_game_pkg.sv | 17 +
 rtl/kid_death_ctrl_if.sv | 26 ++
 rtl/banner_address.sv | 42 ++++
 rtl/kid_death_ctrl.sv | 148 ++++++++++++++
 tb/tb_kid_death_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/kid_game_pkg.sv
// Shared game-state types and sprite-memory layout for the kid/trap blocks.
// The banner sprite sits directly after the two 1024-word apple frames.
package kid_game_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        DYING    = 2'd1,
        GAMEOVER = 2'd2,
        RESPAWN  = 2'd3
    } game_state_t;

    localparam logic [7:0]  RESTART_KEY = 8'h15;
    localparam logic [24:0] APPLE_BASE  = 25'd15360;
    localparam logic [24:0] BANNER_BASE = 25'd17408;
    localparam logic [9:0]  DEATH_MAX   = 10'd999;

endpackage

// File: rtl/kid_death_ctrl_if.sv
// Bundle between the trap/keyboard/VGA side (master) and the death controller (slave).
interface kid_death_ctrl_if;

    logic        hitApple;
    logic        hitSpike;
    logic [7:0]  keycode;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        trap_reset;
    logic        kid_freeze;
    logic        kid_visible;
    logic        isGameOver;
    logic [24:0] GameOver_address;
    logic [9:0]  death_count;

    modport master (
        output hitApple, hitSpike, keycode, DrawX, DrawY,
        input  trap_reset, kid_freeze, kid_visible, isGameOver, GameOver_address, death_count
    );

    modport slave (
        input  hitApple, hitSpike, keycode, DrawX, DrawY,
        output trap_reset, kid_freeze, kid_visible, isGameOver, GameOver_address, death_count
    );

endinterface

// File: rtl/banner_address.sv
// Combinational "GAME OVER" banner hit test and sprite address, laid out like
// the apple address generator (row-major, BANNER_W words per row).
module banner_address
    import kid_game_pkg::*;
#(
    parameter int unsigned BANNER_X = 200,
    parameter int unsigned BANNER_Y = 216,
    parameter int unsigned BANNER_W = 240,
    parameter int unsigned BANNER_H = 48
) (
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        enable,
    output logic        isGameOver,
    output logic [24:0] GameOver_address
);

    logic [24:0] x_ext;
    logic [24:0] y_ext;
    logic [24:0] x_off;
    logic [24:0] y_off;
    logic        in_x;
    logic        in_y;

    assign x_ext = 25'(DrawX);
    assign y_ext = 25'(DrawY);
    assign x_off = x_ext - 25'(BANNER_X);
    assign y_off = y_ext - 25'(BANNER_Y);

    // Right and bottom edges are exclusive.
    assign in_x = (x_ext >= 25'(BANNER_X)) && (x_ext < 25'(BANNER_X + BANNER_W));
    assign in_y = (y_ext >= 25'(BANNER_Y)) && (y_ext < 25'(BANNER_Y + BANNER_H));

    always_comb begin
        isGameOver       = enable && in_x && in_y;
        GameOver_address = '0;
        if (isGameOver) begin
            GameOver_address = BANNER_BASE + x_off + (y_off * 25'(BANNER_W));
        end
    end

endmodule

// File: rtl/kid_death_ctrl.sv
// Kid death / game-over / respawn sequencer, one update per frame_clk.
// Optional saturating death counter enabled by defining DEATH_COUNT_EN.
module kid_death_ctrl
    import kid_game_pkg::*;
#(
    parameter int unsigned DEATH_FRAMES = 30,
    parameter int unsigned BLINK_FRAMES = 4,
    parameter int unsigned RESET_FRAMES = 2,
    parameter int unsigned BANNER_X     = 200,
    parameter int unsigned BANNER_Y     = 216,
    parameter int unsigned BANNER_W     = 240,
    parameter int unsigned BANNER_H     = 48
) (
    input  logic       frame_clk,
    input  logic       Reset_h,
    kid_death_ctrl_if.slave bus
);

    localparam int CNT_W = 8;

    game_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_prev_q, key_prev_d;
    logic             trap_reset_q, trap_reset_d;
    logic             kid_freeze_q, kid_freeze_d;
    logic             kid_visible_q, kid_visible_d;
    logic             key_is_r;
    logic             restart_edge;
    logic             hit;

    assign key_is_r     = (bus.keycode == RESTART_KEY);
    assign restart_edge = key_is_r && !key_prev_q;
    assign hit          = bus.hitApple | bus.hitSpike;
    assign key_prev_d   = key_is_r;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            PLAY: begin
                // A hit outranks a restart press in the same frame.
                if (hit) begin
                    state_d = DYING;
                    cnt_d   = '0;
                end else if (restart_edge) begin
                    state_d = RESPAWN;
                    cnt_d   = '0;
                end
            end
            DYING: begin
                if (cnt_q == CNT_W'(DEATH_FRAMES - 1)) begin
                    state_d = GAMEOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAMEOVER: begin
                if (restart_edge) begin
                    state_d = RESPAWN;
                    cnt_d   = '0;
                end
            end
            RESPAWN: begin
                if (cnt_q == CNT_W'(RESET_FRAMES - 1)) begin
                    state_d = PLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PLAY;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they switch on the same edge as the FSM.
    always_comb begin
        trap_reset_d = (state_d == RESPAWN);
        kid_freeze_d = (state_d != PLAY);
        case (state_d)
            DYING:    kid_visible_d = (((cnt_d / CNT_W'(BLINK_FRAMES)) & CNT_W'(1)) == '0);
            GAMEOVER: kid_visible_d = 1'b0;
            default:  kid_visible_d = 1'b1;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q       <= PLAY;
            cnt_q         <= '0;
            key_prev_q    <= 1'b0;
            trap_reset_q  <= 1'b0;
            kid_freeze_q  <= 1'b0;
            kid_visible_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_prev_q    <= key_prev_d;
            trap_reset_q  <= trap_reset_d;
            kid_freeze_q  <= kid_freeze_d;
            kid_visible_q <= kid_visible_d;
        end
    end

    assign bus.trap_reset  = trap_reset_q;
    assign bus.kid_freeze  = kid_freeze_q;
    assign bus.kid_visible = kid_visible_q;

`ifdef DEATH_COUNT_EN
    logic [9:0] death_q, death_d;

    always_comb begin
        death_d = death_q;
        if ((state_q == PLAY) && hit && (death_q != DEATH_MAX)) begin
            death_d = death_q + 10'd1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset_h) begin
        if (Reset_h) begin
            death_q <= '0;
        end else begin
            death_q <= death_d;
        end
    end

    assign bus.death_count = death_q;
`else
    assign bus.death_count = 10'd0;
`endif

    banner_address #(
        .BANNER_X (BANNER_X),
        .BANNER_Y (BANNER_Y),
        .BANNER_W (BANNER_W),
        .BANNER_H (BANNER_H)
    ) u_banner (
        .DrawX            (bus.DrawX),
        .DrawY            (bus.DrawY),
        .enable           (state_q == GAMEOVER),
        .isGameOver       (bus.isGameOver),
        .GameOver_address (bus.GameOver_address)
    );

endmodule

// File: tb/tb_kid_death_ctrl.sv
// Self-checking bench for kid_death_ctrl: directed scenarios, a long death/respawn
// loop and randomized frames against a frame-timeline reference model.
module tb_kid_death_ctrl;

    localparam int DEATH_FRAMES = 30;
    localparam int BLINK        = 4;
    localparam int RESET_FRAMES = 2;
    localparam int BX           = 200;
    localparam int BY           = 216;
    localparam int BW           = 240;
    localparam int BH           = 48;
    localparam int BBASE        = 17408;
    localparam logic [7:0] KEY_R = 8'h15;

    localparam int M_PLAY  = 0;
    localparam int M_DYING = 1;
    localparam int M_GO    = 2;
    localparam int M_RESP  = 3;

    logic frame_clk = 1'b0;
    logic Reset_h;

    kid_death_ctrl_if bus();

    kid_death_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_h   (Reset_h),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase plus the frame number at which it was entered.
    int m_phase;
    int m_frame;
    int m_entry;
    int m_deaths;
    bit m_prev_r;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int exp_addr(input int x, input int y, input bit shown);
        if (shown && x >= BX && x < BX + BW && y >= BY && y < BY + BH)
            return BBASE + (x - BX) + (y - BY) * BW;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase  = M_PLAY;
        m_frame  = 0;
        m_entry  = 0;
        m_deaths = 0;
        m_prev_r = 1'b0;
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_entry = m_frame;
    endtask

    task automatic model_step();
        bit r_now;
        bit redge;
        int el;
        r_now    = (bus.keycode == KEY_R);
        redge    = r_now && !m_prev_r;
        m_prev_r = r_now;
        m_frame++;
        el = m_frame - m_entry;
        case (m_phase)
            M_PLAY: begin
                if (bus.hitApple || bus.hitSpike) begin
                    enter(M_DYING);
                    if (m_deaths < 999) m_deaths++;
                end else if (redge) begin
                    enter(M_RESP);
                end
            end
            M_DYING: if (el == DEATH_FRAMES) enter(M_GO);
            M_GO:    if (redge) enter(M_RESP);
            default: if (el == RESET_FRAMES) enter(M_PLAY);
        endcase
    endtask

    task automatic check_all(input string tag);
        int el;
        bit ev;
        int ea;
        el = m_frame - m_entry;
        if (m_phase == M_DYING)   ev = ((el / BLINK) % 2) == 0;
        else if (m_phase == M_GO) ev = 1'b0;
        else                      ev = 1'b1;
        ea = exp_addr(int'(bus.DrawX), int'(bus.DrawY), m_phase == M_GO);
        check_val({tag, ".trap_reset"},  32'(bus.trap_reset),  32'(m_phase == M_RESP));
        check_val({tag, ".kid_freeze"},  32'(bus.kid_freeze),  32'(m_phase != M_PLAY));
        check_val({tag, ".kid_visible"}, 32'(bus.kid_visible), 32'(ev));
        check_val({tag, ".isGameOver"},  32'(bus.isGameOver),  32'(ea != 0));
        check_val({tag, ".address"},     32'(bus.GameOver_address), ea);
`ifdef DEATH_COUNT_EN
        check_val({tag, ".death_count"}, 32'(bus.death_count), m_deaths);
`else
        check_val({tag, ".death_count"}, 32'(bus.death_count), 0);
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge frame_clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit ha, input bit hs, input logic [7:0] key);
        bus.hitApple = ha;
        bus.hitSpike = hs;
        bus.keycode  = key;
    endtask

    task automatic probe(input string tag, input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 Reset_h = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 Reset_h = 1'b0;
    endtask

    initial begin
        Reset_h = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        model_reset();
        #1 Reset_h = 1'b1;
        #1;
        check_all("reset");
        #1 Reset_h = 1'b0;

        for (int i = 0; i < 3; i++) tick("play_idle");

        // Apple hit, then hold R through DYING into GAMEOVER.
        drive(1'b1, 1'b0, 8'h00);
        tick("hit_apple");
        drive(1'b0, 1'b0, KEY_R);
        for (int i = 0; i < DEATH_FRAMES; i++) tick("dying");
        check_val("go_visible", 32'(bus.kid_visible), 0);

        probe("probe_tl", 200, 216);
        check_val("tl_is", 32'(bus.isGameOver), 1);
        check_val("tl_addr", 32'(bus.GameOver_address), 17408);
        probe("probe_br", 439, 263);
        check_val("br_addr", 32'(bus.GameOver_address), 28927);
        probe("probe_right", 440, 263);
        check_val("right_is", 32'(bus.isGameOver), 0);
        check_val("right_addr", 32'(bus.GameOver_address), 0);
        tick("go_hold");
        probe("probe_left", 199, 216);
        probe("probe_bottom", 200, 264);

        for (int i = 0; i < 3; i++) tick("go_held_key");
        drive(1'b0, 1'b0, 8'h00);
        tick("go_release");
        drive(1'b0, 1'b0, KEY_R);
        tick("go_press");
        check_val("resp_trap_reset", 32'(bus.trap_reset), 1);
        drive(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) tick("respawn");

        // Spike plus restart edge in the same PLAY frame: hit wins.
        drive(1'b0, 1'b0, 8'h00);
        tick("pre_combo");
        drive(1'b0, 1'b1, KEY_R);
        tick("hit_and_key");
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick("dying2");
        async_reset("rst_mid_dying");
        tick("after_rst");

        // Restart edge alone in PLAY.
        drive(1'b0, 1'b0, KEY_R);
        tick("play_restart");
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) tick("play_respawn");

        // Repeated full death cycles, long enough to reach counter saturation.
        bus.DrawX = 10'd320;
        bus.DrawY = 10'd240;
        for (int d = 0; d < 1001; d++) begin
            drive(1'b1, 1'b0, 8'h00);
            tick("loop_hit");
            drive(1'b0, 1'b0, 8'h00);
            for (int i = 0; i < DEATH_FRAMES; i++) tick("loop_dying");
            drive(1'b0, 1'b0, KEY_R);
            tick("loop_restart");
            drive(1'b0, 1'b0, 8'h00);
            for (int i = 0; i < RESET_FRAMES; i++) tick("loop_respawn");
        end

        for (int i = 0; i < 3000; i++) begin
            bus.hitApple = ($urandom_range(0, 15) == 0);
            bus.hitSpike = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: bus.keycode = KEY_R;
                1: bus.keycode = 8'h00;
                2: bus.keycode = 8'($urandom);
                default: ;
            endcase
            bus.DrawX = 10'($urandom_range(190, 450));
            bus.DrawY = 10'($urandom_range(205, 275));
            if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
